// File: rtl/frame_scheduler_pkg.sv
// frame_scheduler_pkg
//   Shared definitions for the frame scheduler slice: controller state
//   encoding, default geometry constants and the audio sample type.
package frame_scheduler_pkg;

  localparam int DEF_CHANNELS = 8;   // mic channels captured per frame
  localparam int DEF_FRAME_W  = 8;   // frame counter width (256-frame ring)
  localparam int OVR_W        = 8;   // overrun counter width

  typedef logic [15:0] sample_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_START   = 2'd2,
    ST_RUN     = 2'd3
  } sched_state_e;

endpackage

// File: rtl/frame_scheduler_sched_timer.sv
// sched_timer
//   Down-counter bounding how long the downstream sequencer may run.
//   Ports:
//     ck, rst  - clock, asynchronous active-high reset
//     load     - reload so that expired rises on the TIMEOUT-th enabled cycle
//     enable   - count down one step (holds at zero)
//     expired  - count has reached zero
module sched_timer #(
  parameter int TIMEOUT = 1000
) (
  input  logic ck,
  input  logic rst,
  input  logic load,
  input  logic enable,
  output logic expired
);

  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] RELOAD = W'(TIMEOUT - 1);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = RELOAD;
    end else if (enable && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/frame_scheduler.sv
// frame_scheduler
//   Captures one 16-bit sample per mic channel into the audio RAM at each
//   I2S frame start, then kicks a downstream sequencer and supervises it.
//   Ports:
//     ck, rst                 - clock, asynchronous active-high reset
//     frame_strobe            - frame start pulse (one ck wide)
//     host_hold, host_frame   - host owns the RAM / frame index shown meanwhile
//     mic_data, chan_sel      - sample for the currently selected channel
//     ram_we/waddr/wdata      - audio RAM write port, address {chan, frame}
//     frame                   - current frame index (host_frame while held)
//     seq_start/run/done/error- sequencer handshake
//     busy                    - controller not idle
//     timeout, err            - sticky status, cleared on reset or seq_start
//     overruns                - frame strobes that arrived while busy
//   Build option: FRAME_SCHEDULER_OVERRUN_EN enables the overrun counter;
//   otherwise overruns reads zero and no counter is built.
module frame_scheduler
  import frame_scheduler_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int FRAME_W  = DEF_FRAME_W,
  parameter int TIMEOUT  = 1000
) (
  input  logic                               ck,
  input  logic                               rst,
  input  logic                               frame_strobe,
  input  logic                               host_hold,
  input  logic [FRAME_W-1:0]                 host_frame,
  input  logic [15:0]                        mic_data,
  output logic [$clog2(CHANNELS)-1:0]        chan_sel,
  output logic                               ram_we,
  output logic [$clog2(CHANNELS)+FRAME_W-1:0] ram_waddr,
  output logic [15:0]                        ram_wdata,
  output logic [FRAME_W-1:0]                 frame,
  output logic                               seq_start,
  output logic                               seq_run,
  input  logic                               seq_done,
  input  logic                               seq_error,
  output logic                               busy,
  output logic                               timeout,
  output logic                               err,
  output logic [7:0]                         overruns
);

  localparam int CS_W = $clog2(CHANNELS);
  localparam logic [CS_W-1:0] LAST_CHAN = CS_W'(CHANNELS - 1);

  sched_state_e        state_q, state_d;
  logic [FRAME_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic [CS_W-1:0]     chan_sel_q, chan_sel_d;
  logic                timeout_q, timeout_d;
  logic                err_q, err_d;
  logic                strobe_ok;
  logic                tmr_load, tmr_en, tmr_expired;
  sample_t             wdata;

  // A strobe only starts a frame when the host is not holding the RAM.
  assign strobe_ok = frame_strobe && !host_hold;

  sched_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .ck      (ck),
    .rst     (rst),
    .load    (tmr_load),
    .enable  (tmr_en),
    .expired (tmr_expired)
  );

  // State register
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      frame_cnt_q <= '0;
      chan_sel_q  <= '0;
      timeout_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      chan_sel_q  <= chan_sel_d;
      timeout_q   <= timeout_d;
      err_q       <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    chan_sel_d  = chan_sel_q;
    timeout_d   = timeout_q;
    err_d       = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (strobe_ok) begin
          frame_cnt_d = frame_cnt_q + FRAME_W'(1);
          chan_sel_d  = '0;
          state_d     = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        // Channel count is a power of two, so the increment wraps to 0.
        chan_sel_d = chan_sel_q + CS_W'(1);
        if (chan_sel_q == LAST_CHAN) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        timeout_d = 1'b0;
        err_d     = 1'b0;
        state_d   = ST_RUN;
      end
      ST_RUN: begin
        // A new frame pre-empts completion; completion pre-empts expiry.
        if (strobe_ok) begin
          frame_cnt_d = frame_cnt_q + FRAME_W'(1);
          chan_sel_d  = '0;
          state_d     = ST_CAPTURE;
        end else if (seq_done) begin
          if (seq_error) begin
            err_d = 1'b1;
          end
          state_d = ST_IDLE;
        end else if (tmr_expired) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy      = (state_q != ST_IDLE);
    ram_we    = (state_q == ST_CAPTURE);
    seq_start = (state_q == ST_START);
    seq_run   = (state_q == ST_RUN);
    tmr_load  = (state_q == ST_START);
    tmr_en    = (state_q == ST_RUN);
    chan_sel  = chan_sel_q;
    ram_waddr = {chan_sel_q, frame_cnt_q};
    wdata     = mic_data;
    ram_wdata = wdata;
    frame     = host_hold ? host_frame : frame_cnt_q;
    timeout   = timeout_q;
    err       = err_q;
  end

`ifdef FRAME_SCHEDULER_OVERRUN_EN
  logic [OVR_W-1:0] ovr_q, ovr_d;

  always_comb begin
    ovr_d = ovr_q;
    if (strobe_ok && (state_q != ST_IDLE) && (ovr_q != '1)) begin
      ovr_d = ovr_q + OVR_W'(1);
    end
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      ovr_q <= '0;
    end else begin
      ovr_q <= ovr_d;
    end
  end

  assign overruns = ovr_q;
`else
  assign overruns = '0;
`endif

endmodule

// File: tb/tb_frame_scheduler.sv
// tb_frame_scheduler
//   Randomized self-checking bench for frame_scheduler against a
//   transaction-level model (frame index, sticky flags, overrun count).
module tb_frame_scheduler;

  localparam int CH = 8;
  localparam int FW = 8;
  localparam int TO = 1000;

`ifdef FRAME_SCHEDULER_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic        ck = 1'b0;
  logic        rst = 1'b1;
  logic        frame_strobe = 1'b0;
  logic        host_hold = 1'b0;
  logic [7:0]  host_frame = '0;
  logic [15:0] mic_data = '0;
  logic        seq_done = 1'b0;
  logic        seq_error = 1'b0;
  logic [2:0]  chan_sel;
  logic        ram_we;
  logic [10:0] ram_waddr;
  logic [15:0] ram_wdata;
  logic [7:0]  frame;
  logic        seq_start, seq_run, busy, timeout, err;
  logic [7:0]  overruns;

  frame_scheduler #(.CHANNELS(CH), .FRAME_W(FW), .TIMEOUT(TO)) dut (
    .ck(ck), .rst(rst), .frame_strobe(frame_strobe), .host_hold(host_hold),
    .host_frame(host_frame), .mic_data(mic_data), .chan_sel(chan_sel),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .frame(frame), .seq_start(seq_start), .seq_run(seq_run),
    .seq_done(seq_done), .seq_error(seq_error), .busy(busy),
    .timeout(timeout), .err(err), .overruns(overruns)
  );

  always #5 ck = ~ck;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  int mdl_frame = 0;
  int mdl_ovr   = 0;
  bit mdl_to    = 1'b0;
  bit mdl_err   = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge ck);
    #1;
  endtask

  task automatic note_overrun();
    if (OVR_EN && mdl_ovr < 255) mdl_ovr++;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"},     32'(busy), 0);
    check({tag, "_we"},       32'(ram_we), 0);
    check({tag, "_start"},    32'(seq_start), 0);
    check({tag, "_run"},      32'(seq_run), 0);
    check({tag, "_timeout"},  32'(timeout), 0);
    check({tag, "_err"},      32'(err), 0);
    check({tag, "_ovr"},      32'(overruns), 0);
    check({tag, "_chan"},     32'(chan_sel), 0);
    check({tag, "_frame"},    32'(frame), 0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"},    32'(busy), 0);
    check({tag, "_we"},      32'(ram_we), 0);
    check({tag, "_run"},     32'(seq_run), 0);
    check({tag, "_start"},   32'(seq_start), 0);
    check({tag, "_timeout"}, 32'(timeout), 32'(mdl_to));
    check({tag, "_err"},     32'(err), 32'(mdl_err));
    check({tag, "_ovr"},     32'(overruns), 32'(mdl_ovr));
    check({tag, "_frame"},   32'(frame), host_hold ? 32'(host_frame) : 32'(mdl_frame));
  endtask

  task automatic strobe_from_idle();
    frame_strobe = 1'b1;
    #1;
    check("strobe_idle_busy", 32'(busy), 0);
    cyc();
    frame_strobe = 1'b0;
    mdl_frame = (mdl_frame + 1) % 256;
  endtask

  // Walks the capture burst, the START pulse and the first RUN cycle.
  // With rst_at >= 0, reset is applied at that channel and the task ends idle.
  task automatic capture(input int rst_at);
    for (int c = 0; c < CH; c++) begin
      mic_data = 16'($urandom);
      frame_strobe = ($urandom_range(0, 5) == 0);
      #1;
      if (c == rst_at) begin
        rst = 1'b1;
        frame_strobe = 1'b0;
        #1;
        mdl_frame = 0; mdl_ovr = 0; mdl_to = 1'b0; mdl_err = 1'b0;
        check_reset_vals("midcap_rst");
        cyc();
        rst = 1'b0;
        #1;
        check_idle("after_rst");
        return;
      end
      check("cap_we",    32'(ram_we), 1);
      check("cap_chan",  32'(chan_sel), 32'(c));
      check("cap_addr",  32'(ram_waddr), 32'(c * 256 + mdl_frame));
      check("cap_data",  32'(ram_wdata), 32'(mic_data));
      check("cap_frame", 32'(frame), 32'(mdl_frame));
      check("cap_busy",  32'(busy), 1);
      check("cap_run",   32'(seq_run), 0);
      check("cap_ovr",   32'(overruns), 32'(mdl_ovr));
      if (frame_strobe) note_overrun();
      cyc();
    end
    frame_strobe = ($urandom_range(0, 3) == 0);
    #1;
    check("start_pulse", 32'(seq_start), 1);
    check("start_we",    32'(ram_we), 0);
    check("start_run",   32'(seq_run), 0);
    check("start_busy",  32'(busy), 1);
    check("start_frame", 32'(frame), 32'(mdl_frame));
    if (frame_strobe) note_overrun();
    cyc();
    frame_strobe = 1'b0;
    mdl_to = 1'b0;
    mdl_err = 1'b0;
    #1;
    check("run0_start",   32'(seq_start), 0);
    check("run0_run",     32'(seq_run), 1);
    check("run0_timeout", 32'(timeout), 0);
    check("run0_err",     32'(err), 0);
    check("run0_ovr",     32'(overruns), 32'(mdl_ovr));
  endtask

  // Runs the sequencer phase: done at RUN cycle n_done, or abort by strobe
  // at RUN cycle abort_at, otherwise the run expires after TO cycles.
  task automatic run_phase(input int n_done, input bit error, input int abort_at);
    for (int k = 0; k < TO; k++) begin
      if (k == abort_at) begin
        frame_strobe = 1'b1;
        seq_done = $urandom_range(0, 1);
        #1;
        check("abort_run", 32'(seq_run), 1);
        cyc();
        frame_strobe = 1'b0;
        seq_done = 1'b0;
        mdl_frame = (mdl_frame + 1) % 256;
        note_overrun();
        #1;
        check("abort_run_drop", 32'(seq_run), 0);
        check("abort_ovr",      32'(overruns), 32'(mdl_ovr));
        return;
      end
      if (k == n_done) begin
        seq_done = 1'b1;
        seq_error = error;
        #1;
        check("done_run", 32'(seq_run), 1);
        cyc();
        seq_done = 1'b0;
        seq_error = 1'b0;
        if (error) mdl_err = 1'b1;
        #1;
        check_idle("after_done");
        return;
      end
      seq_error = $urandom_range(0, 1);
      #1;
      check("run_run",     32'(seq_run), 1);
      check("run_busy",    32'(busy), 1);
      check("run_we",      32'(ram_we), 0);
      check("run_timeout", 32'(timeout), 0);
      cyc();
      seq_error = 1'b0;
    end
    mdl_to = 1'b1;
    #1;
    check_idle("after_timeout");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int iter;
    #2;
    check_reset_vals("reset");
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    check_idle("idle0");

    // Basic frame: capture then done after 50 cycles
    strobe_from_idle();
    capture(-1);
    run_phase(50, 1'b0, -1);

    // Error on completion is sticky until the next seq_start
    strobe_from_idle();
    capture(-1);
    run_phase($urandom_range(1, 30), 1'b1, -1);
    repeat (3) begin cyc(); check_idle("err_sticky"); end
    strobe_from_idle();
    capture(-1);
    run_phase(5, 1'b0, -1);

    // Timeout, sticky while idle, cleared by next seq_start
    strobe_from_idle();
    capture(-1);
    run_phase(TO + 5, 1'b0, -1);
    repeat (3) begin cyc(); check_idle("to_sticky"); end
    strobe_from_idle();
    capture(-1);
    run_phase(3, 1'b0, -1);

    // Abort at RUN cycle 10: capture restarts on the next frame
    strobe_from_idle();
    capture(-1);
    run_phase(-1, 1'b0, 10);
    capture(-1);
    run_phase(4, 1'b0, -1);

    // Random frames until the counter reaches 0xFF
    iter = 0;
    while (mdl_frame != 255 && iter < 600) begin
      iter++;
      strobe_from_idle();
      capture(-1);
      if (mdl_frame < 250 && $urandom_range(0, 4) == 0) begin
        run_phase(-1, 1'b0, $urandom_range(0, 3));
        capture(-1);
      end
      run_phase($urandom_range(0, 6), 1'($urandom_range(0, 1)), -1);
      if ($urandom_range(0, 1) == 1) cyc();
    end
    check("reach_ff", 32'(frame), 32'hFF);

    // Host hold: frame shows host_frame, strobes ignored
    host_hold = 1'b1;
    host_frame = 8'h42;
    #1;
    check("hold_frame", 32'(frame), 32'h42);
    repeat (4) begin
      frame_strobe = 1'b1;
      #1;
      check("hold_we", 32'(ram_we), 0);
      cyc();
      frame_strobe = 1'b0;
      check_idle("hold_idle");
    end
    host_hold = 1'b0;
    #1;
    check("release_frame", 32'(frame), 32'hFF);
    strobe_from_idle();
    check("wrap_frame", 32'(frame), 32'h00);
    capture(-1);
    run_phase(2, 1'b0, -1);

    // Reset mid-capture at chan_sel=3, then no writes until the next strobe
    strobe_from_idle();
    capture(3);
    repeat (10) begin
      mic_data = 16'($urandom);
      #1;
      check("post_rst_we",   32'(ram_we), 0);
      check("post_rst_busy", 32'(busy), 0);
      cyc();
    end
    strobe_from_idle();
    capture(-1);
    run_phase(1, 1'b0, -1);
    check("post_rst_frame", 32'(frame), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/frame_scheduler.md
FRAME_SCHEDULER -- requirements
Module: frame_scheduler

Interface
REQ-001 SHALL have parameter CHANNELS, default 8, number of mic channels captured per frame (power of two, 2..16).
REQ-002 SHALL have parameter FRAME_W, default 8, frame counter width (256-frame audio ring).
REQ-003 SHALL have parameter TIMEOUT, default 1000, max ck cycles allowed in RUN before abort.
REQ-004 SHALL have port ck  in  1  single clock for all logic.
REQ-005 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports frame_strobe in 1 (I2S frame start pulse, one ck wide) and host_hold in 1 (host owns audio RAM).
REQ-007 SHALL have ports host_frame in FRAME_W (frame used while held) and mic_data in 16 (sample for chan_sel).
REQ-008 SHALL have ports chan_sel out $clog2(CHANNELS), ram_we out 1, ram_waddr out $clog2(CHANNELS)+FRAME_W, and ram_wdata out 16.
REQ-009 SHALL have ports frame out FRAME_W, seq_start out 1, seq_run out 1, seq_done in 1, and seq_error in 1.
REQ-010 SHALL have ports busy out 1, timeout out 1 (sticky), err out 1 (sticky), and overruns out 8.

Function
REQ-011 SHALL implement states IDLE, CAPTURE, START, RUN.
REQ-012 IDLE: frame_strobe with host_hold=0 SHALL increment frame_counter (wraps 2^FRAME_W-1 -> 0), zero chan_sel, and enter CAPTURE next cycle.
REQ-013 IDLE: frame_strobe with host_hold=1 SHALL be ignored (no count change, no overrun).
REQ-014 CAPTURE: ram_we=1 for exactly CHANNELS consecutive cycles with chan_sel 0..CHANNELS-1, ram_waddr={chan_sel,frame_counter}, ram_wdata=mic_data (combinational).
REQ-015 CAPTURE after chan_sel=CHANNELS-1 SHALL enter START; START SHALL assert seq_start for one cycle, set seq_run=1, clear the timeout counter, and enter RUN.
REQ-016 RUN: seq_done=1 SHALL return to IDLE and drop seq_run next cycle; seq_error=1 together with seq_done SHALL set err.
REQ-017 RUN: TIMEOUT cycles without seq_done SHALL set timeout, drop seq_run, and return to IDLE.
REQ-018 RUN: frame_strobe SHALL abort the run (seq_run=0), increment frame_counter, and enter CAPTURE, with seq_done that cycle ignored.
REQ-019 frame_strobe in CAPTURE or START SHALL be ignored for sequencing.
REQ-020 frame SHALL equal host_frame when host_hold=1, else frame_counter; ram_we SHALL never assert while state is IDLE.
REQ-021 busy SHALL be 1 in every state except IDLE.
REQ-022 timeout and err SHALL clear only on reset or a seq_start pulse.

Reset
REQ-023 rst SHALL asynchronously force IDLE, frame_counter=0, chan_sel=0, ram_we=0, seq_start=0, seq_run=0, timeout=0, err=0, overruns=0.
REQ-024 rst asserted mid-CAPTURE or mid-RUN SHALL abandon the operation with no further RAM write after deassertion.

Configuration
REQ-025 With FRAME_SCHEDULER_OVERRUN_EN defined, overruns SHALL increment (saturating at 255) on each frame_strobe arriving in CAPTURE, START or RUN with host_hold=0.
REQ-026 Without FRAME_SCHEDULER_OVERRUN_EN, overruns SHALL be tied to 0 and no counter logic SHALL be built; all other behaviour is unchanged.

Structure
REQ-027 A shared package SHALL hold the state encoding enum, the default CHANNELS/FRAME_W constants, and the 16-bit sample type.
REQ-028 The RUN timeout down-counter SHALL be a sub-module named sched_timer (load, enable, expired).

Verification
REQ-029 Reset, then a strobe in IDLE -> next 8 cycles ram_we=1, ram_waddr=0x001..0x701 step 0x100, then one seq_start pulse, seq_run=1.
REQ-030 In RUN, drive seq_done after 50 cycles -> IDLE next cycle, seq_run=0, busy=0, timeout=0.
REQ-031 In RUN, hold seq_done low for 1000 cycles -> timeout=1, seq_run=0, IDLE; the next seq_start clears timeout.
REQ-032 Strobe at RUN cycle 10 with the macro defined -> overruns=1, frame incremented, capture restarts at chan_sel=0; without the macro, overruns=0.
REQ-033 host_hold=1, host_frame=0x42 -> frame=0x42, strobes cause no ram_we; with frame_counter=0xFF, one strobe after release -> frame=0x00.
REQ-034 Assert rst at CAPTURE chan_sel=3 -> all outputs at reset values immediately, and no ram_we after release until the next strobe.
